// File: rtl/img_pkt_checker_pkg.sv
// Shared types and default parameters for the image-packet receive stage.
package img_pkt_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 16;
    localparam int unsigned DEF_LEN_W  = 12;
    localparam int unsigned DEF_CSUM_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    typedef struct packed {
        logic                  last;
        logic [DEF_DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/img_pkt_checker_fifo.sv
// Synchronous FIFO with extra-MSB wrap pointers; read data is combinational from the head entry.
module sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    // Same index with differing wrap bit means the writer lapped the reader.
    assign full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign empty  = (r_wptr == r_rptr);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign rdata  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/img_pkt_checker.sv
// Image-packet receive stage: header latch, byte accumulation with modular checksum,
// buffered valid/ready output stream and per-packet checksum verdict.
module img_pkt_checker
    import img_pkt_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned LEN_W  = DEF_LEN_W,
    parameter int unsigned CSUM_W = DEF_CSUM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hdr_valid,
    input  logic [LEN_W-1:0]  hdr_len,
    input  logic [CSUM_W-1:0] hdr_csum,
    input  logic              in_strb,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done,
    output logic              csum_ok,
    output logic [CSUM_W-1:0] csum_calc,
    output logic              err_drop
);

    state_t            r_state;
    logic [LEN_W-1:0]  r_remain;
    logic [CSUM_W-1:0] r_acc;
    logic [CSUM_W-1:0] r_exp;
    logic              r_done;
    logic              r_ok;
    logic [CSUM_W-1:0] r_calc;
    logic              r_err;

    logic              w_full;
    logic              w_empty;
    logic              w_in_ready;
    logic              w_xfer;
    logic              w_pop;
    logic              w_last;
    logic [CSUM_W-1:0] w_acc_next;
    logic [DATA_W:0]   w_wdata;
    logic [DATA_W:0]   w_rdata;

    assign w_in_ready = (r_state == RECV) && !w_full;
    assign w_xfer     = in_strb && w_in_ready;
    assign w_pop      = !w_empty && out_ready;
    assign w_last     = (r_remain == LEN_W'(1));
    assign w_acc_next = r_acc + CSUM_W'(in_data);
    assign w_wdata    = {w_last, in_data};

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_xfer),
        .pop   (w_pop),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty)
    );

    // Verdict registers are loaded on the edge entering CHECK so they line up with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_remain <= '0;
            r_acc    <= '0;
            r_exp    <= '0;
            r_done   <= 1'b0;
            r_ok     <= 1'b0;
            r_calc   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (hdr_valid) begin
                        r_remain <= hdr_len;
                        r_exp    <= hdr_csum;
                        r_acc    <= '0;
                        r_err    <= 1'b0;
                        if (hdr_len == '0) begin
                            r_state <= CHECK;
                            r_done  <= 1'b1;
                            r_calc  <= '0;
                            r_ok    <= (hdr_csum == '0);
                        end else begin
                            r_state <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (in_strb && !w_in_ready) r_err <= 1'b1;
                    if (w_xfer) begin
                        r_acc    <= w_acc_next;
                        r_remain <= r_remain - LEN_W'(1);
                        if (w_last) begin
                            r_state <= CHECK;
                            r_done  <= 1'b1;
                            r_calc  <= w_acc_next;
                            r_ok    <= (w_acc_next == r_exp);
                        end
                    end
                end
                CHECK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : w_rdata[DATA_W-1:0];
    assign out_last  = !w_empty && w_rdata[DATA_W];
    assign done      = r_done;
    assign csum_ok   = r_ok;
    assign csum_calc = r_calc;
    assign err_drop  = r_err;

endmodule

// File: tb/tb_img_pkt_checker.sv
// Self-checking bench for img_pkt_checker: table vectors, hand-written corner sequences
// and randomized packets compared against a transaction-level model every cycle.
module tb_img_pkt_checker;
    import img_pkt_pkg::*;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        hdr_valid;
    logic [11:0] hdr_len;
    logic [15:0] hdr_csum;
    logic        in_strb;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        done;
    logic        csum_ok;
    logic [15:0] csum_calc;
    logic        err_drop;

    img_pkt_checker #(
        .DATA_W (8),
        .DEPTH  (DEPTH),
        .LEN_W  (12),
        .CSUM_W (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hdr_valid (hdr_valid),
        .hdr_len   (hdr_len),
        .hdr_csum  (hdr_csum),
        .in_strb   (in_strb),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .csum_ok   (csum_ok),
        .csum_calc (csum_calc),
        .err_drop  (err_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: phase 0 waiting for header, 1 collecting bytes, 2 verdict cycle.
    fifo_entry_t sb[$];
    int          m_phase = 0;
    int          m_left  = 0;
    int          m_sum   = 0;
    int          m_exp   = 0;
    int          m_calc  = 0;
    bit          m_ok    = 0;
    bit          m_err   = 0;
    logic [7:0]  pkt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_phase = 0;
        m_left  = 0;
        m_sum   = 0;
        m_exp   = 0;
        m_calc  = 0;
        m_ok    = 0;
        m_err   = 0;
    endtask

    task automatic compare_outputs();
        check("in_ready", 32'(in_ready), 32'((m_phase == 1) && (sb.size() < DEPTH)));
        check("out_valid", 32'(out_valid), 32'(sb.size() > 0));
        if (sb.size() > 0) begin
            check("out_data", 32'(out_data), 32'(sb[0].data));
            check("out_last", 32'(out_last), 32'(sb[0].last));
        end else begin
            check("out_data_idle", 32'(out_data), 32'd0);
            check("out_last_idle", 32'(out_last), 32'd0);
        end
        check("done", 32'(done), 32'(m_phase == 2));
        check("csum_ok", 32'(csum_ok), 32'(m_ok));
        check("csum_calc", 32'(csum_calc), 32'(m_calc));
        check("err_drop", 32'(err_drop), 32'(m_err));
    endtask

    // One clock: model transfer decisions use pre-edge state, outputs are compared 1 ns after the edge.
    task automatic tick(output bit acc);
        bit          rdy;
        bit          pop;
        fifo_entry_t e;
        rdy = (m_phase == 1) && (sb.size() < DEPTH);
        pop = (sb.size() > 0) && out_ready;
        acc = rdy && in_strb && !rst;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (pop) void'(sb.pop_front());
            case (m_phase)
                0: if (hdr_valid) begin
                    m_exp  = int'(hdr_csum);
                    m_sum  = 0;
                    m_err  = 0;
                    m_left = int'(hdr_len);
                    if (m_left == 0) begin
                        m_phase = 2;
                        m_calc  = 0;
                        m_ok    = (m_exp == 0);
                    end else begin
                        m_phase = 1;
                    end
                end
                1: if (in_strb) begin
                    if (acc) begin
                        m_sum  = (m_sum + int'(in_data)) % 65536;
                        e.last = (m_left == 1);
                        e.data = in_data;
                        sb.push_back(e);
                        m_left--;
                        if (m_left == 0) begin
                            m_phase = 2;
                            m_calc  = m_sum;
                            m_ok    = (m_sum == m_exp);
                        end
                    end else begin
                        m_err = 1;
                    end
                end
                default: m_phase = 0;
            endcase
        end
        compare_outputs();
    endtask

    task automatic drain();
        bit acc;
        int budget = 0;
        hdr_valid = 0;
        in_strb   = 0;
        out_ready = 1;
        while (sb.size() > 0 && budget < 200) begin
            tick(acc);
            budget++;
        end
        if (sb.size() > 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Sends pkt[] as one packet; rnd adds strobe gaps, output backpressure and ignored header noise.
    task automatic send_pkt(input int len, input logic [15:0] csum, input bit rnd);
        bit acc;
        int idx = 0;
        int budget = 0;
        hdr_valid = 1;
        hdr_len   = 12'(len);
        hdr_csum  = csum;
        in_strb   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        in_data   = 8'($urandom);
        tick(acc);
        hdr_valid = 0;
        while (idx < len && budget < 5000) begin
            in_strb = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data = pkt[idx];
            if (rnd) begin
                out_ready = ($urandom_range(0, 3) != 0);
                hdr_valid = 1'($urandom_range(0, 1));
                hdr_len   = 12'($urandom);
                hdr_csum  = 16'($urandom);
            end
            tick(acc);
            if (acc) idx++;
            budget++;
        end
        if (idx < len) check("pkt_timeout", 32'(idx), 32'(len));
        check("done_pulse", 32'(done), 32'd1);
        hdr_valid = 0;
        in_strb   = 0;
        tick(acc);
    endtask

    typedef struct {
        int              len;
        logic [15:0]     csum;
        logic [3:0][7:0] bytes;
        bit              ok;
        logic [15:0]     calc;
    } vec_t;

    vec_t vt[6];

    initial begin
        bit acc;
        int idx;
        int budget;
        int sum;

        vt[0] = '{4, 16'h0010, {8'h0A, 8'h03, 8'h02, 8'h01}, 1'b1, 16'h0010};
        vt[1] = '{4, 16'h0011, {8'h0A, 8'h03, 8'h02, 8'h01}, 1'b0, 16'h0010};
        vt[2] = '{0, 16'h0000, 32'h0, 1'b1, 16'h0000};
        vt[3] = '{0, 16'h0005, 32'h0, 1'b0, 16'h0000};
        vt[4] = '{1, 16'h00FF, {8'h00, 8'h00, 8'h00, 8'hFF}, 1'b1, 16'h00FF};
        vt[5] = '{3, 16'h0000, {8'h00, 8'h00, 8'h80, 8'h80}, 1'b0, 16'h0100};

        rst       = 1;
        hdr_valid = 0;
        hdr_len   = '0;
        hdr_csum  = '0;
        in_strb   = 0;
        in_data   = '0;
        out_ready = 1;
        model_reset();
        tick(acc);
        tick(acc);
        rst = 0;
        tick(acc);

        for (int i = 0; i < 6; i++) begin
            pkt.delete();
            for (int j = 0; j < vt[i].len; j++) pkt.push_back(vt[i].bytes[j]);
            send_pkt(vt[i].len, vt[i].csum, 0);
            check("tbl_csum_ok", 32'(csum_ok), 32'(vt[i].ok));
            check("tbl_csum_calc", 32'(csum_calc), 32'(vt[i].calc));
            drain();
        end

        // Backpressure: 20 bytes into a 16-entry FIFO with output stalled.
        pkt.delete();
        for (int j = 0; j < 20; j++) pkt.push_back(8'(j + 1));
        out_ready = 0;
        hdr_valid = 1;
        hdr_len   = 12'd20;
        hdr_csum  = 16'h00D2;
        tick(acc);
        hdr_valid = 0;
        for (int j = 0; j < 16; j++) begin
            in_strb = 1;
            in_data = pkt[j];
            tick(acc);
        end
        check("bp_ready_low", 32'(in_ready), 32'd0);
        in_data = 8'hEE;
        for (int j = 0; j < 3; j++) tick(acc);
        check("bp_err_drop", 32'(err_drop), 32'd1);
        out_ready = 1;
        idx = 16;
        budget = 0;
        while (idx < 20 && budget < 100) begin
            in_strb = 1;
            in_data = pkt[idx];
            tick(acc);
            if (acc) idx++;
            budget++;
        end
        if (idx < 20) check("bp_timeout", 32'(idx), 32'd20);
        check("bp_done", 32'(done), 32'd1);
        check("bp_calc", 32'(csum_calc), 32'h00D2);
        check("bp_ok", 32'(csum_ok), 32'd1);
        in_strb = 0;
        tick(acc);
        drain();

        // 300 x 0xFF wraps the 16-bit accumulator.
        pkt.delete();
        for (int j = 0; j < 300; j++) pkt.push_back(8'hFF);
        send_pkt(300, 16'h2AD4, 0);
        check("wrap_calc", 32'(csum_calc), 32'h2AD4);
        check("wrap_ok", 32'(csum_ok), 32'd1);
        drain();

        // Reset after 3 of 8 bytes aborts the packet.
        hdr_valid = 1;
        hdr_len   = 12'd8;
        hdr_csum  = 16'h1234;
        tick(acc);
        hdr_valid = 0;
        for (int j = 0; j < 3; j++) begin
            in_strb = 1;
            in_data = 8'(8'h10 + j);
            tick(acc);
        end
        #3 rst = 1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_csum_ok", 32'(csum_ok), 32'd0);
        check("rst_csum_calc", 32'(csum_calc), 32'd0);
        check("rst_err_drop", 32'(err_drop), 32'd0);
        model_reset();
        in_strb = 0;
        tick(acc);
        rst = 0;
        tick(acc);
        pkt.delete();
        pkt.push_back(8'h21);
        pkt.push_back(8'h43);
        send_pkt(2, 16'h0064, 0);
        check("post_rst_ok", 32'(csum_ok), 32'd1);
        check("post_rst_calc", 32'(csum_calc), 32'h0064);

        // Randomized packets, with a new header sometimes arriving before the FIFO drains.
        for (int p = 0; p < 25; p++) begin
            int len;
            len = $urandom_range(0, 40);
            pkt.delete();
            sum = 0;
            for (int j = 0; j < len; j++) begin
                pkt.push_back(8'($urandom));
                sum = (sum + int'(pkt[j])) % 65536;
            end
            for (int k = $urandom_range(0, 3); k > 0; k--) begin
                in_strb   = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
                tick(acc);
            end
            send_pkt(len, ($urandom_range(0, 1) != 0) ? 16'(sum) : 16'($urandom), 1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
